// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC vectoring engine.
//   state_t   : controller states
//   ANGLE_180 : half-turn in 16-bit binary angle units
//   atan_lut  : atan(2^-i) in 16-bit binary angle units (2^16 = 360 deg)
package cordic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_X,
    LOAD_Y,
    PRE,
    ITER,
    DONE
  } state_t;

  localparam logic [15:0] ANGLE_180 = 16'h8000;

  function automatic logic [15:0] atan_lut(input logic [3:0] idx);
    logic [15:0] a;
    case (idx)
      4'd0:    a = 16'h2000;
      4'd1:    a = 16'h12E4;
      4'd2:    a = 16'h09FB;
      4'd3:    a = 16'h0511;
      4'd4:    a = 16'h028B;
      4'd5:    a = 16'h0146;
      4'd6:    a = 16'h00A3;
      4'd7:    a = 16'h0051;
      4'd8:    a = 16'h0029;
      4'd9:    a = 16'h0014;
      4'd10:   a = 16'h000A;
      4'd11:   a = 16'h0005;
      4'd12:   a = 16'h0003;
      4'd13:   a = 16'h0001;
      default: a = 16'h0000;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/cordic_vec_stage.sv
// Combinational CORDIC vectoring micro-rotation.
// Ports:
//   x_in, y_in   : current vector, signed WORD_WIDTH+2
//   z_in         : accumulated binary angle, WORD_WIDTH bits (wraps)
//   iter         : micro-rotation index i (shift amount and ATAN index)
//   x_out, y_out : rotated vector
//   z_out        : updated angle
module cordic_vec_stage
  import cordic_pkg::*;
#(
  parameter int WORD_WIDTH = 16
) (
  input  logic signed [WORD_WIDTH+1:0] x_in,
  input  logic signed [WORD_WIDTH+1:0] y_in,
  input  logic        [WORD_WIDTH-1:0] z_in,
  input  logic        [3:0]            iter,
  output logic signed [WORD_WIDTH+1:0] x_out,
  output logic signed [WORD_WIDTH+1:0] y_out,
  output logic        [WORD_WIDTH-1:0] z_out
);

  logic signed [WORD_WIDTH+1:0] x_sh;
  logic signed [WORD_WIDTH+1:0] y_sh;
  logic        [WORD_WIDTH-1:0] atan_w;

  always_comb begin
    x_sh   = x_in >>> iter;
    y_sh   = y_in >>> iter;
    // Rescale the 16-bit table to the angle width: keep its top WORD_WIDTH bits.
    atan_w = WORD_WIDTH'({atan_lut(iter), 16'h0000} >> (32 - WORD_WIDTH));
    // Rotate toward y = 0; both updates use the pre-rotation x and y.
    if (!y_in[WORD_WIDTH+1]) begin
      x_out = x_in + y_sh;
      y_out = y_in - x_sh;
      z_out = z_in + atan_w;
    end else begin
      x_out = x_in - y_sh;
      y_out = y_in + x_sh;
      z_out = z_in - atan_w;
    end
  end

endmodule

// File: rtl/cordic_vec_engine.sv
// Iterative CORDIC vectoring engine.
// Fetches x then y from an upstream 4:1 mux, rotates the vector onto the
// +x axis and reports magnitude (times CORDIC gain K) and atan2(y, x).
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   start    : begin a conversion (only honoured while idle)
//   mux_out  : signed operand from the mux
//   sel      : mux select (X_SEL while fetching x, Y_SEL while fetching y)
//   busy     : high whenever not idle
//   done     : one-cycle pulse when mag/angle are updated
//   mag      : unsigned magnitude * K, WORD_WIDTH+1 bits
//   angle    : binary angle, 2^WORD_WIDTH = 360 deg
module cordic_vec_engine
  import cordic_pkg::*;
#(
  parameter int         WORD_WIDTH = 16,
  parameter int         ITERATIONS = 14,
  parameter logic [1:0] X_SEL      = 2'd0,
  parameter logic [1:0] Y_SEL      = 2'd1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic signed [WORD_WIDTH-1:0] mux_out,
  output logic        [1:0]            sel,
  output logic                         busy,
  output logic                         done,
  output logic        [WORD_WIDTH:0]   mag,
  output logic        [WORD_WIDTH-1:0] angle
);

  localparam int              XW    = WORD_WIDTH + 2;
  localparam logic [3:0]      LAST  = 4'(ITERATIONS - 1);
  localparam logic [WORD_WIDTH-1:0] Z_180 =
    WORD_WIDTH'({ANGLE_180, 16'h0000} >> (32 - WORD_WIDTH));

  state_t                 state;
  logic signed [XW-1:0]   x;
  logic signed [XW-1:0]   y;
  logic [WORD_WIDTH-1:0]  z;
  logic [3:0]             iter;

  logic signed [XW-1:0]   x_nx;
  logic signed [XW-1:0]   y_nx;
  logic [WORD_WIDTH-1:0]  z_nx;

  cordic_vec_stage #(
    .WORD_WIDTH (WORD_WIDTH)
  ) u_stage (
    .x_in  (x),
    .y_in  (y),
    .z_in  (z),
    .iter  (iter),
    .x_out (x_nx),
    .y_out (y_nx),
    .z_out (z_nx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sel   <= 2'd0;
      busy  <= 1'b0;
      done  <= 1'b0;
      mag   <= '0;
      angle <= '0;
      x     <= '0;
      y     <= '0;
      z     <= '0;
      iter  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD_X;
            sel   <= X_SEL;
            busy  <= 1'b1;
          end
        end
        LOAD_X: begin
          x     <= {{2{mux_out[WORD_WIDTH-1]}}, mux_out};
          sel   <= Y_SEL;
          state <= LOAD_Y;
        end
        LOAD_Y: begin
          y     <= {{2{mux_out[WORD_WIDTH-1]}}, mux_out};
          sel   <= 2'd0;
          state <= PRE;
        end
        PRE: begin
          // Fold left half-plane into the right half-plane by a 180 deg turn;
          // the two guard bits make -(-2^(W-1)) representable.
          if (x[XW-1]) begin
            x <= -x;
            y <= -y;
            z <= Z_180;
          end else begin
            z <= '0;
          end
          iter  <= '0;
          state <= ITER;
        end
        ITER: begin
          x    <= x_nx;
          y    <= y_nx;
          z    <= z_nx;
          iter <= iter + 4'd1;
          if (iter == LAST) begin
            state <= DONE;
            done  <= 1'b1;
            mag   <= x_nx[WORD_WIDTH:0];
            angle <= z_nx;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          sel   <= 2'd0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_vec_engine.sv
// Testbench for cordic_vec_engine: real-arithmetic reference (sqrt, atan2,
// exact gain product) plus literal expectations for the canonical vectors.
module tb_cordic_vec_engine;

  localparam int         W  = 16;
  localparam int         N  = 14;
  localparam logic [1:0] XS = 2'd0;
  localparam logic [1:0] YS = 2'd1;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic signed [W-1:0] mux_out;
  logic [1:0]          sel;
  logic                busy;
  logic                done;
  logic [W:0]          mag;
  logic [W-1:0]        angle;

  logic signed [W-1:0] op_x;
  logic signed [W-1:0] op_y;

  int tests = 0;
  int fails = 0;

  int qx[$];
  int qy[$];
  int qta[$];
  int qtm[$];

  always #5 clk = ~clk;

  // Upstream 4:1 mux: inputs 2 and 3 carry junk so a wrong sel shows up.
  always_comb begin
    if (sel == XS)        mux_out = op_x;
    else if (sel == YS)   mux_out = op_y;
    else if (sel == 2'd2) mux_out = 16'sh1234;
    else                  mux_out = -16'sd2222;
  end

  cordic_vec_engine #(
    .WORD_WIDTH (W),
    .ITERATIONS (N),
    .X_SEL      (XS),
    .Y_SEL      (YS)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .mux_out (mux_out),
    .sel     (sel),
    .busy    (busy),
    .done    (done),
    .mag     (mag),
    .angle   (angle)
  );

  function automatic real k_gain();
    real k = 1.0;
    for (int i = 0; i < N; i++) k = k * $sqrt(1.0 + 2.0 ** (-2 * i));
    return k;
  endfunction

  function automatic real exp_mag(input int x, input int y);
    return $sqrt(real'(x) * real'(x) + real'(y) * real'(y)) * k_gain();
  endfunction

  function automatic real exp_ang(input int x, input int y);
    real a;
    a = $atan2(real'(y), real'(x)) * 65536.0 / (2.0 * 3.14159265358979);
    if (a < 0.0) a = a + 65536.0;
    return a;
  endfunction

  task automatic chk_near(input string name, input real act, input real exp,
                          input real tol, input bit circ);
    real d;
    d = act - exp;
    if (circ) begin
      while (d > 32768.0)  d = d - 65536.0;
      while (d < -32768.0) d = d + 65536.0;
    end
    tests++;
    if (d > tol || d < -tol) begin
      fails++;
      $display("FAIL %s: got %0.2f, expected %0.2f (tol %0.1f)", name, act, exp, tol);
    end
  endtask

  task automatic chk_eq(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Compare process: every done pulse must match the oldest launched operand.
  int cx, cy, cta, ctm;
  always @(negedge clk) begin
    if (!rst && done) begin
      if (qx.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1, expected no pending conversion");
      end else begin
        cx  = qx.pop_front();
        cy  = qy.pop_front();
        cta = qta.pop_front();
        ctm = qtm.pop_front();
        chk_near("model_mag", real'(mag), exp_mag(cx, cy), real'(ctm), 1'b0);
        chk_near("model_angle", real'(angle), exp_ang(cx, cy), real'(cta), 1'b1);
      end
    end
  end

  // Launch one conversion, check mux selects and busy, return latency in edges.
  task automatic run_conv(input int x, input int y, input int ta, input int tm,
                          output int lat);
    bit seen;
    seen = 1'b0;
    lat  = -1;
    op_x = W'(x);
    op_y = W'(y);
    qx.push_back(x);
    qy.push_back(y);
    qta.push_back(ta);
    qtm.push_back(tm);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk_eq("sel_load_x", int'(sel), int'(XS));
    chk_eq("busy_running", int'(busy), 1);
    for (int n = 1; n <= 40 && !seen; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) chk_eq("sel_load_y", int'(sel), int'(YS));
      if (n == 2) chk_eq("sel_after_load", int'(sel), 0);
      if (done) begin
        seen = 1'b1;
        lat  = n;
      end
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got no done in 40 cycles, expected one");
      void'(qx.pop_back());
      void'(qy.pop_back());
      void'(qta.pop_back());
      void'(qtm.pop_back());
    end
  endtask

  task automatic directed(input string tag, input int x, input int y,
                          input int a_lit, input int m_lit, input int ta, input int tm);
    int lat;
    run_conv(x, y, ta, tm, lat);
    chk_eq({tag, "_latency"}, lat, N + 3);
    chk_near({tag, "_angle_lit"}, real'(angle), real'(a_lit), real'(ta), 1'b1);
    if (m_lit >= 0) chk_near({tag, "_mag_lit"}, real'(mag), real'(m_lit), real'(tm), 1'b0);
    @(posedge clk);
    #1;
    chk_eq({tag, "_done_one_cycle"}, int'(done), 0);
    chk_eq({tag, "_idle_after"}, int'(busy), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, dc, rx, ry;
    rst   = 1'b1;
    start = 1'b0;
    op_x  = '0;
    op_y  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_eq("reset_busy", int'(busy), 0);
    chk_eq("reset_done", int'(done), 0);
    chk_eq("reset_mag", int'(mag), 0);
    chk_eq("reset_angle", int'(angle), 0);
    chk_eq("reset_sel", int'(sel), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    directed("x_axis",   16384,      0, 16'h0000, 26981, 2, 4);
    directed("y_axis",       0,  16384, 16'h4000, 26981, 2, 4);
    directed("diag",     16384,  16384, 16'h2000, 38156, 2, 6);
    directed("neg_diag",-16384, -16384, 16'hA000,    -1, 2, 8);
    directed("neg_full",-32768,      0, 16'h8000, 53962, 2, 6);

    // Second start while iterating must be dropped.
    op_x = 16'sd12000;
    op_y = -16'sd5000;
    qx.push_back(12000);
    qy.push_back(-5000);
    qta.push_back(12);
    qtm.push_back(24);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dc = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (done) dc++;
    end
    chk_eq("restart_ignored_done_count", dc, 1);

    // Reset in the middle of a conversion.
    op_x = 16'sd20000;
    op_y = 16'sd7000;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_eq("midrst_busy", int'(busy), 0);
    chk_eq("midrst_done", int'(done), 0);
    chk_eq("midrst_mag", int'(mag), 0);
    chk_eq("midrst_angle", int'(angle), 0);
    chk_eq("midrst_sel", int'(sel), 0);
    @(negedge clk);
    rst = 1'b0;
    dc = 0;
    for (int n = 0; n < 25; n++) begin
      @(posedge clk);
      #1;
      if (done) dc++;
    end
    chk_eq("midrst_no_done", dc, 0);
    directed("after_rst", 0, -16384, 16'hC000, 26981, 2, 4);

    // Randomised vectors, magnitude kept >= 8192 so truncation error stays small.
    for (int t = 0; t < 24; t++) begin
      do begin
        rx = int'($urandom_range(0, 65535)) - 32768;
        ry = int'($urandom_range(0, 65535)) - 32768;
      end while (rx * rx + ry * ry < 8192 * 8192);
      run_conv(rx, ry, 12, 24, lat);
      chk_eq("rand_latency", lat, N + 3);
      @(posedge clk);
    end

    repeat (3) @(posedge clk);
    chk_eq("queue_drained", qx.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
